// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe style board blocks: cell codes,
// button bundle, move decode and the width helper used for port sizing.
package gato_pkg;

  localparam int N_MIN = 3;
  localparam int N_MAX = 8;

  typedef enum logic [1:0] {
    VACIO = 2'b00,
    JUG2  = 2'b01,
    JUG1  = 2'b11
  } celda_t;

  // One decoded cursor move per cycle; NINGUNO leaves elige eligible.
  typedef enum logic [2:0] {
    MOV_NINGUNO,
    MOV_ABAJO,
    MOV_ARRIBA,
    MOV_IZQ,
    MOV_DER
  } mov_t;

  typedef struct packed {
    logic abajo;
    logic arriba;
    logic izq;
    logic der;
    logic elige;
  } botones_t;

  // Smallest r with 2**r >= valor.
  function automatic int clog2(input int valor);
    int r;
    r = 0;
    while ((1 << r) < valor) r++;
    return r;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// One-bit rising-edge detector: registered history, edge = now high and
// low at the previous clk edge. History clears on rst only.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic flanco
);

  logic previo;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) previo <= 1'b0;
    else     previo <= din;
  end

  assign flanco = din & ~previo;

endmodule

// File: rtl/selector_tablero.sv
// Cursor and board controller: moves a cursor over an N x N grid with
// debounced buttons and records alternating player marks on selection.
module selector_tablero
  import gato_pkg::*;
#(
  parameter  int N    = 3,
  parameter  int WRAP = 0,
  localparam int CW   = clog2(N*N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              limpiar,
  input  logic              boton_arriba,
  input  logic              boton_abajo,
  input  logic              boton_izq,
  input  logic              boton_der,
  input  logic              boton_elige,
  output logic [CW-1:0]     cuadro,
  output logic [2*N*N-1:0]  tablero,
  output logic              turno,
  output logic              p1_mm,
  output logic              p2_mm,
  output logic              invalido,
  output logic              lleno
);

  localparam int            RW         = clog2(N);
  localparam int            CELDAS     = N * N;
  localparam logic [RW-1:0] ULTIMO     = RW'(N - 1);
  localparam logic [RW-1:0] CENTRO     = RW'(N / 2);
  localparam logic [CW-1:0] CUADRO_INI = CW'((N / 2) * N + (N / 2) + 1);

  logic [4:0] botones_raw;
  logic [4:0] flancos_raw;
  botones_t   flanco;

  assign botones_raw = {boton_abajo, boton_arriba, boton_izq, boton_der, boton_elige};

  for (genvar b = 0; b < 5; b++) begin : g_det
    detector_flanco u_det (
      .clk    (clk),
      .rst    (rst),
      .din    (botones_raw[b]),
      .flanco (flancos_raw[b])
    );
  end

  assign flanco = botones_t'(flancos_raw);

  logic [RW-1:0]     fila_q, col_q;
  logic [RW-1:0]     fila_n, col_n;
  mov_t              mov;
  logic              elige_ok;
  logic [CW-1:0]     indice;
  logic [2*N*N-1:0]  tablero_n;
  logic              turno_n, p1_n, p2_n, inv_n, lleno_n;

  // Fixed priority: abajo > arriba > izq > der; losers are dropped.
  always_comb begin
    mov = MOV_NINGUNO;
    if      (flanco.abajo)  mov = MOV_ABAJO;
    else if (flanco.arriba) mov = MOV_ARRIBA;
    else if (flanco.izq)    mov = MOV_IZQ;
    else if (flanco.der)    mov = MOV_DER;
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    fila_n = fila_q;
    col_n  = col_q;
    case (mov)
      MOV_ABAJO: begin
        if (fila_q != ULTIMO) fila_n = fila_q + RW'(1);
        else if (WRAP != 0)   fila_n = '0;
      end
      MOV_ARRIBA: begin
        if (fila_q != '0)     fila_n = fila_q - RW'(1);
        else if (WRAP != 0)   fila_n = ULTIMO;
      end
      MOV_IZQ: begin
        if (col_q != '0)      col_n = col_q - RW'(1);
        else if (WRAP != 0)   col_n = ULTIMO;
      end
      MOV_DER: begin
        if (col_q != ULTIMO)  col_n = col_q + RW'(1);
        else if (WRAP != 0)   col_n = '0;
      end
      default: ;
    endcase
  end

  assign elige_ok = flanco.elige && (mov == MOV_NINGUNO);
  assign indice   = CW'(int'(fila_q) * N + int'(col_q));

  always_comb begin
    tablero_n = tablero;
    turno_n   = turno;
    p1_n      = 1'b0;
    p2_n      = 1'b0;
    inv_n     = 1'b0;
    if (elige_ok) begin
      if (celda_t'(tablero[2*indice +: 2]) == VACIO && !lleno) begin
        tablero_n[2*indice +: 2] = turno ? JUG2 : JUG1;
        p1_n    = ~turno;
        p2_n    = turno;
        turno_n = ~turno;
      end else begin
        inv_n = 1'b1;
      end
    end
  end

  // Fullness is taken from the next board so lleno rises with the last write.
  always_comb begin
    lleno_n = 1'b1;
    for (int k = 0; k < CELDAS; k++) begin
      if (celda_t'(tablero_n[2*k +: 2]) == VACIO) lleno_n = 1'b0;
    end
  end

  // rst and limpiar reach the same state here; they differ only in the
  // edge-detector history, which only rst clears.
  // NOTE: the board is a plain register vector, not a memory, so it is reset
  // explicitly along with the rest of the state.
  always_ff @(posedge clk) begin
    if (rst || limpiar) begin
      fila_q   <= CENTRO;
      col_q    <= CENTRO;
      cuadro   <= CUADRO_INI;
      tablero  <= '0;
      turno    <= 1'b0;
      p1_mm    <= 1'b0;
      p2_mm    <= 1'b0;
      invalido <= 1'b0;
      lleno    <= 1'b0;
    end else begin
      fila_q   <= fila_n;
      col_q    <= col_n;
      cuadro   <= CW'(int'(fila_n) * N + int'(col_n) + 1);
      tablero  <= tablero_n;
      turno    <= turno_n;
      p1_mm    <= p1_n;
      p2_mm    <= p2_n;
      invalido <= inv_n;
      lleno    <= lleno_n;
    end
  end

endmodule

// File: tb/tb_selector_tablero.sv
// Directed bench for selector_tablero: clamp (N=3), wrap (N=3) and N=5
// instances driven by a vector table plus short hand-written sequences.
module tb_selector_tablero;

  localparam logic [4:0] B_NO = 5'b00000;
  localparam logic [4:0] B_AB = 5'b10000;
  localparam logic [4:0] B_AR = 5'b01000;
  localparam logic [4:0] B_IZ = 5'b00100;
  localparam logic [4:0] B_DE = 5'b00010;
  localparam logic [4:0] B_EL = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT A: N=3, WRAP=0 ----------------
  logic        a_rst, a_lim;
  logic [4:0]  a_btn;
  logic [3:0]  a_cuadro;
  logic [17:0] a_tablero;
  logic        a_turno, a_p1, a_p2, a_inv, a_lleno;

  selector_tablero #(.N(3), .WRAP(0)) dut_a (
    .clk(clk), .rst(a_rst), .limpiar(a_lim),
    .boton_arriba(a_btn[3]), .boton_abajo(a_btn[4]), .boton_izq(a_btn[2]),
    .boton_der(a_btn[1]), .boton_elige(a_btn[0]),
    .cuadro(a_cuadro), .tablero(a_tablero), .turno(a_turno),
    .p1_mm(a_p1), .p2_mm(a_p2), .invalido(a_inv), .lleno(a_lleno)
  );

  // ---------------- DUT B: N=3, WRAP=1 ----------------
  logic        b_rst, b_lim;
  logic [4:0]  b_btn;
  logic [3:0]  b_cuadro;
  logic [17:0] b_tablero;
  logic        b_turno, b_p1, b_p2, b_inv, b_lleno;

  selector_tablero #(.N(3), .WRAP(1)) dut_b (
    .clk(clk), .rst(b_rst), .limpiar(b_lim),
    .boton_arriba(b_btn[3]), .boton_abajo(b_btn[4]), .boton_izq(b_btn[2]),
    .boton_der(b_btn[1]), .boton_elige(b_btn[0]),
    .cuadro(b_cuadro), .tablero(b_tablero), .turno(b_turno),
    .p1_mm(b_p1), .p2_mm(b_p2), .invalido(b_inv), .lleno(b_lleno)
  );

  // ---------------- DUT C: N=5, WRAP=0 ----------------
  logic        c_rst, c_lim;
  logic [4:0]  c_btn;
  logic [4:0]  c_cuadro;
  logic [49:0] c_tablero;
  logic        c_turno, c_p1, c_p2, c_inv, c_lleno;

  selector_tablero #(.N(5), .WRAP(0)) dut_c (
    .clk(clk), .rst(c_rst), .limpiar(c_lim),
    .boton_arriba(c_btn[3]), .boton_abajo(c_btn[4]), .boton_izq(c_btn[2]),
    .boton_der(c_btn[1]), .boton_elige(c_btn[0]),
    .cuadro(c_cuadro), .tablero(c_tablero), .turno(c_turno),
    .p1_mm(c_p1), .p2_mm(c_p2), .invalido(c_inv), .lleno(c_lleno)
  );

  task automatic check(input string nombre, input logic [63:0] actual,
                       input logic [63:0] esperado);
    checks++;
    if (actual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nombre, actual, esperado);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] cu, input logic [17:0] tb,
                         input logic tu, input logic p1, input logic p2,
                         input logic inv, input logic ll);
    check({tag, " cuadro"},   64'(a_cuadro),  64'(cu));
    check({tag, " tablero"},  64'(a_tablero), 64'(tb));
    check({tag, " turno"},    64'(a_turno),   64'(tu));
    check({tag, " p1_mm"},    64'(a_p1),      64'(p1));
    check({tag, " p2_mm"},    64'(a_p2),      64'(p2));
    check({tag, " invalido"}, 64'(a_inv),     64'(inv));
    check({tag, " lleno"},    64'(a_lleno),   64'(ll));
  endtask

  typedef struct {
    logic        lim;
    logic [4:0]  btn;
    logic [3:0]  cuadro;
    logic [17:0] tablero;
    logic        turno;
    logic        p1;
    logic        p2;
    logic        inv;
    logic        lleno;
  } vector_t;

  localparam logic [17:0] C5 = 18'h00300;  // cell 5 = player 1

  vector_t tabla[24];

  typedef struct {
    logic [4:0] btn;
    logic [3:0] celda;
  } jugada_t;

  jugada_t jugadas[9];

  initial begin
    logic [17:0] exp_tab;
    logic        exp_turno;

    tabla[0]  = '{1'b0, B_DE,        4'd6, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[1]  = '{1'b0, B_NO,        4'd6, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[2]  = '{1'b0, B_DE,        4'd6, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[3]  = '{1'b0, B_NO,        4'd6, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[4]  = '{1'b0, B_AR,        4'd3, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[5]  = '{1'b0, B_NO,        4'd3, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[6]  = '{1'b0, B_AR,        4'd3, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[7]  = '{1'b0, B_NO,        4'd3, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[8]  = '{1'b1, B_DE,        4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[9]  = '{1'b0, B_DE,        4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[10] = '{1'b0, B_NO,        4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[11] = '{1'b0, B_EL,        4'd5, C5,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tabla[12] = '{1'b0, B_NO,        4'd5, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[13] = '{1'b0, B_EL,        4'd5, C5,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tabla[14] = '{1'b0, B_NO,        4'd5, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[15] = '{1'b0, B_AB | B_EL, 4'd8, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[16] = '{1'b0, B_NO,        4'd8, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[17] = '{1'b0, B_IZ | B_DE, 4'd7, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[18] = '{1'b0, B_NO,        4'd7, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[19] = '{1'b0, B_AB | B_AR, 4'd7, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[20] = '{1'b0, B_NO,        4'd7, C5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[21] = '{1'b1, B_EL,        4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[22] = '{1'b0, B_EL,        4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tabla[23] = '{1'b0, B_NO,        4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Move (or none) then elige; covers every cell once starting at cell 5.
    jugadas[0] = '{B_NO, 4'd5};
    jugadas[1] = '{B_AR, 4'd2};
    jugadas[2] = '{B_IZ, 4'd1};
    jugadas[3] = '{B_AB, 4'd4};
    jugadas[4] = '{B_AB, 4'd7};
    jugadas[5] = '{B_DE, 4'd8};
    jugadas[6] = '{B_DE, 4'd9};
    jugadas[7] = '{B_AR, 4'd6};
    jugadas[8] = '{B_AR, 4'd3};

    a_rst = 1'b1; a_lim = 1'b0; a_btn = B_NO;
    b_rst = 1'b1; b_lim = 1'b0; b_btn = B_DE;  // der held through reset
    c_rst = 1'b1; c_lim = 1'b0; c_btn = B_NO;
    #2;
    step();
    check_a("reset", 4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("B reset cuadro", 64'(b_cuadro), 64'd5);
    check("C reset cuadro", 64'(c_cuadro), 64'd13);
    check("C reset tablero", 64'(c_tablero), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // ---- DUT B: held-through-reset edge, then wrap moves ----
    step();
    check("B held-through-reset edge", 64'(b_cuadro), 64'd6);
    step();
    check("B held der acts once", 64'(b_cuadro), 64'd6);
    b_btn = B_NO; step();
    b_btn = B_AR; step(); check("B arriba to 3", 64'(b_cuadro), 64'd3);
    b_btn = B_NO; step();
    b_btn = B_IZ; step(); check("B izq to 2", 64'(b_cuadro), 64'd2);
    b_btn = B_NO; step();
    b_btn = B_IZ; step(); check("B izq to 1", 64'(b_cuadro), 64'd1);
    b_btn = B_NO; step();
    b_btn = B_IZ; step(); check("B wrap izq 1->3", 64'(b_cuadro), 64'd3);
    b_btn = B_NO; step();
    b_btn = B_AR; step(); check("B wrap arriba 3->9", 64'(b_cuadro), 64'd9);
    b_btn = B_NO; step();
    b_btn = B_DE; step(); check("B wrap der 9->7", 64'(b_cuadro), 64'd7);
    b_btn = B_NO; step();
    b_btn = B_AB; step(); check("B wrap abajo 7->1", 64'(b_cuadro), 64'd1);
    b_btn = B_NO; step();

    // ---- DUT C: N=5 held abajo moves once ----
    c_btn = B_AB;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("C held abajo cyc%0d", i), 64'(c_cuadro), 64'd18);
    end
    c_btn = B_NO; step();

    // ---- DUT A: vector table ----
    for (int i = 0; i < 24; i++) begin
      a_lim = tabla[i].lim;
      a_btn = tabla[i].btn;
      step();
      check_a($sformatf("vec%0d", i), tabla[i].cuadro, tabla[i].tablero, tabla[i].turno,
              tabla[i].p1, tabla[i].p2, tabla[i].inv, tabla[i].lleno);
    end
    a_lim = 1'b0; a_btn = B_NO;

    // ---- DUT A: fill the board alternately ----
    exp_tab   = '0;
    exp_turno = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (jugadas[j].btn != B_NO) begin
        a_btn = jugadas[j].btn; step();
        check($sformatf("fill%0d move cuadro", j), 64'(a_cuadro), 64'(jugadas[j].celda));
        a_btn = B_NO; step();
      end
      exp_tab[2*(int'(jugadas[j].celda)-1) +: 2] = exp_turno ? 2'b01 : 2'b11;
      a_btn = B_EL; step();
      check_a($sformatf("fill%0d elige", j), jugadas[j].celda, exp_tab, ~exp_turno,
              ~exp_turno, exp_turno, 1'b0, (j == 8));
      exp_turno = ~exp_turno;
      a_btn = B_NO; step();
      check_a($sformatf("fill%0d release", j), jugadas[j].celda, exp_tab, exp_turno,
              1'b0, 1'b0, 1'b0, (j == 8));
    end
    check("full board pattern", 64'(a_tablero), 64'h37777);

    a_btn = B_EL; step();
    check_a("elige on full", 4'd3, 18'h37777, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    a_btn = B_NO; step();
    check_a("invalido one cycle", 4'd3, 18'h37777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    a_lim = 1'b1; step();
    check_a("limpiar", 4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    a_lim = 1'b0; step();
    check_a("after limpiar", 4'd5, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
